// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg: state encoding, defaults and sizing helpers
// shared by the bcd_conv_scheduler slice.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam int FLUSH_CYCLES_DEF   = 64;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  function automatic int conv_latency(
    input int w,
    input int d
  );
    return w * (2 + 2 * d) + 4;
  endfunction

  function automatic int cnt_width(
    input int a,
    input int b
  );
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/bcd_conv_scheduler_rr_priority_pick.sv
// rr_priority_pick: first eligible channel at or after ptr,
// wrapping around; purely combinational.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 valid
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;

  // descending walk so the nearest channel is written last
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = |eligible;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (eligible[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin share of one bcd_converter.
// Define BCD_SKIP_UNCHANGED_EN to ack unchanged values without converting.
module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 6,
  parameter int DECIMAL_DIGITS = 2,
  parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                                  i_Clock,
  input  logic                                  i_Reset_n,
  input  logic [NUM_REQ-1:0]                    i_Req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]        i_Binary,
  output logic [NUM_REQ-1:0]                    o_Ack,
  output logic [NUM_REQ*DECIMAL_DIGITS*4-1:0]   o_BCD,
  output logic [INPUT_WIDTH-1:0]                o_Conv_Binary,
  output logic                                  o_Conv_Start,
  input  logic [DECIMAL_DIGITS*4-1:0]           i_Conv_BCD,
  input  logic                                  i_Conv_DV,
  output logic                                  o_Busy,
  output logic                                  o_Timeout
);

  localparam int DW  = DECIMAL_DIGITS * 4;
  localparam int PW  = $clog2(NUM_REQ);
  localparam int LAT = conv_latency(INPUT_WIDTH, DECIMAL_DIGITS);
  // never drain for less than one full conversion
  localparam int FLUSH_LEN = (FLUSH_CYCLES > LAT) ? FLUSH_CYCLES : LAT;
  localparam int CW  = cnt_width(FLUSH_LEN, TIMEOUT_CYCLES);

  state_t                       state;
  logic [CW-1:0]                cnt;
  logic [NUM_REQ-1:0]           pend;
  logic [NUM_REQ-1:0]           clr;
  logic [NUM_REQ-1:0]           eligible;
  logic [PW-1:0]                ptr;
  logic [PW-1:0]                grant;
  logic [PW-1:0]                pick;
  logic                         pick_vld;
  logic [NUM_REQ-1:0]           pick_oh;
  logic [NUM_REQ-1:0]           grant_oh;
  logic [INPUT_WIDTH-1:0]       pick_bin;
  logic                         skip_hit;
  logic [NUM_REQ-1:0][DW-1:0]   bcd_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] g);
    return (g == PW'(NUM_REQ - 1)) ? '0 : g + PW'(1);
  endfunction

  assign eligible = pend | i_Req;
  assign pick_oh  = NUM_REQ'(1) << pick;
  assign grant_oh = NUM_REQ'(1) << grant;
  assign o_BCD    = bcd_q;
  assign o_Busy   = (state != ST_IDLE);

  rr_priority_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .eligible(eligible),
    .ptr     (ptr),
    .grant   (pick),
    .valid   (pick_vld)
  );

  always_comb begin
    pick_bin = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == PW'(k))
        pick_bin = i_Binary[k*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

`ifdef BCD_SKIP_UNCHANGED_EN
  logic [NUM_REQ-1:0][INPUT_WIDTH-1:0] last_bin;
  logic [NUM_REQ-1:0]                  last_vld;

  always_comb begin
    skip_hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == PW'(k))
        skip_hit = last_vld[k] && (last_bin[k] == pick_bin);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      last_bin <= '0;
      last_vld <= '0;
    end else if (state == ST_WAIT && i_Conv_DV) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_oh[k]) begin
          last_bin[k] <= o_Conv_Binary;
          last_vld[k] <= 1'b1;
        end
      end
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  always_comb begin
    clr = '0;
    if (state == ST_WAIT && i_Conv_DV)
      clr = grant_oh;
    else if (state == ST_IDLE && pick_vld && skip_hit)
      clr = pick_oh;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= ST_FLUSH;
      cnt           <= '0;
      pend          <= '0;
      ptr           <= '0;
      grant         <= '0;
      bcd_q         <= '0;
      o_Ack         <= '0;
      o_Conv_Binary <= '0;
      o_Conv_Start  <= 1'b0;
      o_Timeout     <= 1'b0;
    end else begin
      pend         <= (pend & ~clr) | i_Req;
      o_Ack        <= '0;
      o_Timeout    <= 1'b0;
      o_Conv_Start <= 1'b0;
      unique case (state)
        ST_FLUSH: begin
          if (cnt == CW'(FLUSH_LEN - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (pick_vld) begin
            if (skip_hit) begin
              o_Ack <= pick_oh;
              ptr   <= nxt(pick);
            end else begin
              grant         <= pick;
              o_Conv_Binary <= pick_bin;
              o_Conv_Start  <= 1'b1;
              cnt           <= '0;
              state         <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_Conv_DV) begin
            for (int k = 0; k < NUM_REQ; k++) begin
              if (grant_oh[k]) bcd_q[k] <= i_Conv_BCD;
            end
            o_Ack <= grant_oh;
            ptr   <= nxt(grant);
            state <= ST_IDLE;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            o_Timeout <= 1'b1;
            cnt       <= '0;
            state     <= ST_FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_FLUSH;
      endcase
    end
  end

endmodule
